// File: rtl/hex_uart_rx_pkg.sv
// Shared constants for the serial hex console: bit period, ASCII codes,
// receiver state encoding and the hex-digit classifier.
package hex_uart_rx_pkg;

   localparam int SERIAL_WCNT = 16;

   localparam logic [7:0] ASC_SP = 8'h20;
   localparam logic [7:0] ASC_CR = 8'h0D;
   localparam logic [7:0] ASC_LF = 8'h0A;
   localparam logic [7:0] ASC_0  = 8'h30;
   localparam logic [7:0] ASC_LA = 8'h61;
   localparam logic [7:0] ASC_UA = 8'h41;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   // Returns {is_hex, nibble}; nibble is zero for non-hex characters.
   function automatic logic [4:0] hex_nibble(input logic [7:0] c);
      logic [7:0] v;
      if (c >= ASC_0 && c <= (ASC_0 + 8'd9)) begin
         v = c - ASC_0;
         return {1'b1, v[3:0]};
      end else if (c >= ASC_LA && c <= (ASC_LA + 8'd5)) begin
         v = c - ASC_LA + 8'd10;
         return {1'b1, v[3:0]};
      end else if (c >= ASC_UA && c <= (ASC_UA + 8'd5)) begin
         v = c - ASC_UA + 8'd10;
         return {1'b1, v[3:0]};
      end else begin
         return 5'd0;
      end
   endfunction

   function automatic logic is_term(input logic [7:0] c);
      return (c == ASC_SP) || (c == ASC_CR) || (c == ASC_LF);
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, mid-bit sampling state machine,
// byte/framing-error strobes and BUSY.
module uart_rx_byte
   import hex_uart_rx_pkg::*;
#(
   parameter int WCNT = SERIAL_WCNT
) (
   input  logic       clk_i,
   input  logic       rst_x_i,
   input  logic       rxd_i,
   output logic [7:0] byte_o,
   output logic       byte_vld_o,
   output logic       frm_err_o,
   output logic       busy_o
);

   localparam int CW   = $clog2(WCNT);
   localparam int HALF = WCNT / 2;

   rx_state_e       state_q, state_d;
   logic            sync1_q, sync2_q, prev_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shr_q, shr_d;
   logic            vld_q, vld_d, err_q, err_d, busy_q;
   logic            fall_s;

   assign fall_s = prev_q & ~sync2_q;

   // Synchronizer idles high so reset never fakes a start edge.
   always_ff @(posedge clk_i or negedge rst_x_i) begin
      if (!rst_x_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rxd_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Next-state logic: cnt counts cycles since the last sample point.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shr_d   = shr_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            bit_d = 3'd0;
            if (fall_s) state_d = RX_START;
            else        state_d = RX_IDLE;
         end
         RX_START: begin
            if (cnt_q == CW'(HALF - 1)) begin
               cnt_d = '0;
               if (sync2_q) state_d = RX_IDLE;
               else         state_d = RX_DATA;
            end else begin
               state_d = RX_START;
            end
         end
         RX_DATA: begin
            if (cnt_q == CW'(WCNT - 1)) begin
               cnt_d = '0;
               shr_d = {sync2_q, shr_q[7:1]};
               if (bit_q == 3'd7) state_d = RX_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               state_d = RX_DATA;
            end
         end
         RX_STOP: begin
            if (cnt_q == CW'(WCNT - 1)) begin
               cnt_d   = '0;
               vld_d   = sync2_q;
               err_d   = ~sync2_q;
               state_d = RX_IDLE;
            end else begin
               state_d = RX_STOP;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = RX_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_x_i) begin
      if (!rst_x_i) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shr_q   <= 8'd0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shr_q   <= shr_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         busy_q  <= (state_d != RX_IDLE);
      end
   end

   assign byte_o     = shr_q;
   assign byte_vld_o = vld_q;
   assign frm_err_o  = err_q;
   assign busy_o     = busy_q;

endmodule

// File: rtl/hex_uart_rx.sv
// ASCII-hex token decoder on top of the byte receiver; emits the parsed
// word with a VALID strobe, or an ERR strobe for a malformed token.
module hex_uart_rx
   import hex_uart_rx_pkg::*;
#(
   parameter int DIGIT = 8,
   parameter int WCNT  = SERIAL_WCNT
) (
   input  logic             CLK,
   input  logic             RST_X,
   input  logic             RXD,
   output logic [DIGIT*4-1:0] DATA,
   output logic             VALID,
   output logic             ERR,
   output logic             BUSY
);

   localparam int DW = DIGIT * 4;
   localparam int NW = $clog2(DIGIT + 1);

   logic [7:0]    rx_byte_s;
   logic          rx_vld_s, rx_ferr_s;
   logic [4:0]    hex_s;
   logic [DW-1:0] acc_q, acc_d, data_q, data_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic          bad_q, bad_d, valid_q, valid_d, err_q, err_d;

   uart_rx_byte #(.WCNT(WCNT)) u_rx (
      .clk_i      (CLK),
      .rst_x_i    (RST_X),
      .rxd_i      (RXD),
      .byte_o     (rx_byte_s),
      .byte_vld_o (rx_vld_s),
      .frm_err_o  (rx_ferr_s),
      .busy_o     (BUSY)
   );

   assign hex_s = hex_nibble(rx_byte_s);

   // Token decode: digits shift in, terminators close the token.
   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bad_d   = bad_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (rx_ferr_s) begin
         bad_d = 1'b1;
      end else if (rx_vld_s) begin
         if (hex_s[4]) begin
            acc_d = {acc_q[DW-5:0], hex_s[3:0]};
            if (cnt_q != {NW{1'b1}}) cnt_d = cnt_q + NW'(1);
            else                     cnt_d = cnt_q;
         end else if (is_term(rx_byte_s)) begin
            if (cnt_q == '0 && !bad_q) begin
               valid_d = 1'b0;
            end else if (bad_q) begin
               err_d = 1'b1;
            end else begin
               data_d  = acc_q;
               valid_d = 1'b1;
            end
            acc_d = '0;
            cnt_d = '0;
            bad_d = 1'b0;
         end else begin
            bad_d = 1'b1;
         end
      end else begin
         bad_d = bad_q;
      end
   end

   // Decoder state and output registers.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         bad_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bad_q   <= bad_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign DATA  = data_q;
   assign VALID = valid_q;
   assign ERR   = err_q;

endmodule
